// File: rtl/psum_load_seq.sv
// psum_load_seq: issues one iteration (p*e) of psum GLB reads per start and tracks iteration/batch progress.
// Latency: first read request the cycle after an accepted start; tag/valid follow each issue by RD_LAT cycles.
// Backpressure: an issue happens only when i_glb_ready is high; address/request hold while it is low.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_load_start, i_abort   start one iteration (IDLE only) / cancel pass (highest priority)
//   i_base_addr, i_layer_n/e/p, i_row_tag   pass configuration
//   i_glb_ready             GLB accepts a read this cycle
//   o_psum_glb_re/_ra       read request and address
//   o_psum_valid/_tag       read data valid and {row, col} tag, RD_LAT after issue
//   o_busy, o_load_done, o_cfg_err   status and one-cycle pulses
module psum_load_seq #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 5,
  parameter int N_W    = 3,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load_start,
  input  logic                     i_abort,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic [N_W-1:0]           i_layer_n,
  input  logic [DIM_W-1:0]         i_layer_e,
  input  logic [DIM_W-1:0]         i_layer_p,
  input  logic [ROW_W-1:0]         i_row_tag,
  input  logic                     i_glb_ready,
  output logic                     o_psum_glb_re,
  output logic [ADDR_W-1:0]        o_psum_glb_ra,
  output logic                     o_psum_valid,
  output logic [ROW_W+COL_W-1:0]   o_psum_tag,
  output logic                     o_busy,
  output logic                     o_load_done,
  output logic                     o_cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_t;

  state_t                   r_state;
  logic [DIM_W-1:0]         r_cnt_p;
  logic [DIM_W-1:0]         r_cnt_e;
  logic [DIM_W-1:0]         r_iter;
  logic [N_W-1:0]           r_batch;
  logic [ROW_W-1:0]         r_row;
  logic                     r_cfg_err;
  logic [RD_LAT-1:0]        r_pv;
  logic [ROW_W+COL_W-1:0]   r_pt [RD_LAT];

  logic                     w_issue;
  logic                     w_cfg_ok;
  logic                     w_p_last;
  logic                     w_e_last;
  logic                     w_iter_last;
  logic                     w_batch_last;
  logic [COL_W-1:0]         w_col;
  logic [ADDR_W-1:0]        w_e;
  logic [ADDR_W-1:0]        w_ee;
  logic [ADDR_W-1:0]        w_pee;

  assign w_issue      = (r_state == S_LOAD) && i_glb_ready;
  assign w_cfg_ok     = (i_layer_n != '0) && (i_layer_e != '0) && (i_layer_p != '0);
  assign w_p_last     = (r_cnt_p == i_layer_p - DIM_W'(1));
  assign w_e_last     = (r_cnt_e == i_layer_e - DIM_W'(1));
  assign w_iter_last  = (r_iter  == i_layer_e - DIM_W'(1));
  assign w_batch_last = (r_batch == i_layer_n - N_W'(1));
  assign w_col        = COL_W'(r_cnt_e) + COL_W'(1);

  // The address is only ever needed mod 2^ADDR_W, so truncating every
  // operand to ADDR_W before the products gives the exact same result.
  assign w_e   = ADDR_W'(i_layer_e);
  assign w_ee  = w_e * w_e;
  assign w_pee = ADDR_W'(i_layer_p) * w_ee;
  assign o_psum_glb_ra = i_base_addr + ADDR_W'(r_batch) * w_pee + ADDR_W'(r_cnt_p) * w_ee
                       + ADDR_W'(r_cnt_e) * w_e + ADDR_W'(r_iter);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_state   <= S_IDLE;
      r_cnt_p   <= '0;
      r_cnt_e   <= '0;
      r_iter    <= '0;
      r_batch   <= '0;
      r_row     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            if (w_cfg_ok) begin
              r_state <= S_LOAD;
              r_row   <= i_row_tag;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (i_glb_ready) begin
            if (w_p_last) begin
              r_cnt_p <= '0;
              if (w_e_last) begin
                r_cnt_e <= '0;
                r_state <= S_UPDATE;
              end else begin
                r_cnt_e <= r_cnt_e + DIM_W'(1);
              end
            end else begin
              r_cnt_p <= r_cnt_p + DIM_W'(1);
            end
          end
        end
        S_UPDATE: begin
          // A full pass ends only when both iteration and batch wrap.
          if (w_iter_last) begin
            r_iter <= '0;
            if (w_batch_last) begin
              r_batch <= '0;
              r_state <= S_DONE;
            end else begin
              r_batch <= r_batch + N_W'(1);
              r_state <= S_IDLE;
            end
          end else begin
            r_iter  <= r_iter + DIM_W'(1);
            r_state <= S_IDLE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-latency shadow of the GLB: carries each issue and its tag so they
  // line up with returning data. Keeps shifting after LOAD exits.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_pv <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pt[k] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pt[0] <= {r_row, w_col};
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pt[k] <= r_pt[k-1];
      end
    end
  end

  assign o_psum_glb_re = (r_state == S_LOAD);
  assign o_busy        = (r_state != S_IDLE);
  assign o_load_done   = (r_state == S_DONE);
  assign o_cfg_err     = r_cfg_err;
  assign o_psum_valid  = r_pv[RD_LAT-1];
  assign o_psum_tag    = r_pt[RD_LAT-1];

endmodule

// File: tb/tb_psum_load_seq.sv
// tb_psum_load_seq: drives two psum_load_seq instances (RD_LAT 2 and 3) from shared stimulus.
// Latency: outputs sampled mid-cycle against a queue-based reference of the read stream.
// Backpressure: i_glb_ready driven from fixed patterns and $urandom.
module tb_psum_load_seq;

  logic        clk, rst, start, abort, ready;
  logic [15:0] base;
  logic [2:0]  lay_n;
  logic [4:0]  lay_e, lay_p;
  logic [3:0]  row;

  logic        re2, v2, busy2, done2, cerr2;
  logic [15:0] ra2;
  logic [7:0]  tag2;
  logic        re3, v3, busy3, done3, cerr3;
  logic [15:0] ra3;
  logic [7:0]  tag3;

  psum_load_seq #(.RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_load_start(start), .i_abort(abort),
    .i_base_addr(base), .i_layer_n(lay_n), .i_layer_e(lay_e), .i_layer_p(lay_p),
    .i_row_tag(row), .i_glb_ready(ready),
    .o_psum_glb_re(re2), .o_psum_glb_ra(ra2), .o_psum_valid(v2), .o_psum_tag(tag2),
    .o_busy(busy2), .o_load_done(done2), .o_cfg_err(cerr2));

  psum_load_seq #(.RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_load_start(start), .i_abort(abort),
    .i_base_addr(base), .i_layer_n(lay_n), .i_layer_e(lay_e), .i_layer_p(lay_p),
    .i_row_tag(row), .i_glb_ready(ready),
    .o_psum_glb_re(re3), .o_psum_glb_ra(ra3), .o_psum_valid(v3), .o_psum_tag(tag3),
    .o_busy(busy3), .o_load_done(done3), .o_cfg_err(cerr3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the pending read stream of the current iteration as a queue,
  // plus how many busy cycles follow the last read and the issue history.
  typedef struct packed { logic [15:0] addr; logic [7:0] tag; } rd_t;
  rd_t         m_q[$];
  int          m_tail, m_iter, m_batch;
  bit          m_done_pass, m_cfg;
  bit          m_vh[8];
  logic [7:0]  m_th[8];

  task automatic model_reset();
    m_q.delete();
    m_tail = 0; m_iter = 0; m_batch = 0; m_done_pass = 0; m_cfg = 0;
    for (int k = 0; k < 8; k++) begin m_vh[k] = 0; m_th[k] = '0; end
  endtask

  task automatic model_edge();
    bit idle0, iss;
    int ni, ei, pi, a;
    rd_t it;
    idle0 = (m_q.size() == 0) && (m_tail == 0);
    iss   = (m_q.size() > 0) && ready && !abort;
    if (abort) begin
      model_reset();
      return;
    end
    for (int k = 7; k > 0; k--) begin m_vh[k] = m_vh[k-1]; m_th[k] = m_th[k-1]; end
    m_vh[0] = iss;
    m_th[0] = iss ? m_q[0].tag : 8'h00;
    m_cfg = 0;
    ni = int'(lay_n); ei = int'(lay_e); pi = int'(lay_p);
    if (m_tail > 0) m_tail--;
    if (iss) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_iter = (m_iter + 1) % ei;
        if (m_iter == 0) m_batch = (m_batch + 1) % ni;
        m_done_pass = (m_iter == 0) && (m_batch == 0);
        m_tail = m_done_pass ? 2 : 1;
      end
    end else if (idle0 && start) begin
      if (ni == 0 || ei == 0 || pi == 0) m_cfg = 1;
      else
        for (int ce = 0; ce < ei; ce++)
          for (int cp = 0; cp < pi; cp++) begin
            a = int'(base) + m_batch*pi*ei*ei + cp*ei*ei + ce*ei + m_iter;
            it.addr = a[15:0];
            it.tag  = {row, 4'(ce + 1)};
            m_q.push_back(it);
          end
    end
  endtask

  task automatic check_model();
    bit eb;
    eb = (m_q.size() > 0) || (m_tail > 0);
    chk("re", re2, m_q.size() > 0);
    chk("busy", busy2, eb);
    chk("busy3", busy3, eb);
    chk("load_done", done2, (m_tail == 1) && m_done_pass);
    chk("cfg_err", cerr2, m_cfg);
    if (m_q.size() > 0) chk("ra", ra2, m_q[0].addr);
    chk("valid_lat2", v2, m_vh[1]);
    if (m_vh[1]) chk("tag_lat2", tag2, m_th[1]);
    chk("valid_lat3", v3, m_vh[2]);
    if (m_vh[2]) chk("tag_lat3", tag3, m_th[2]);
  endtask

  task automatic apply(input bit s, input bit a, input bit r);
    start = s; abort = a; ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [15:0] b, input int n, input int e, input int p, input logic [3:0] rw);
    apply(0, 1, 1); check_model(); tick();
    base = b; lay_n = 3'(n); lay_e = 5'(e); lay_p = 5'(p); row = rw;
  endtask

  logic [15:0] got_ra[$];
  int n_v2, n_v3, n_dn;

  // One start, run to idle; pat bit k is ready in the k-th LOAD-side cycle.
  task automatic run_iter(input bit [15:0] pat, input bit sb);
    bit r;
    got_ra.delete(); n_v2 = 0; n_v3 = 0; n_dn = 0;
    apply(1, 0, 1); check_model(); tick();
    for (int cyc = 1; cyc < 200; cyc++) begin
      r = (cyc <= 16) ? pat[cyc-1] : 1'b1;
      apply(sb, 0, r);
      if (!busy2) break;
      if (re2 && r) got_ra.push_back(ra2);
      if (v2) n_v2++;
      if (v3) n_v3++;
      if (done2) n_dn++;
      check_model(); tick();
    end
    chk("run_reaches_idle", busy2, 0);
    repeat (4) begin
      apply(0, 0, 1);
      if (v2) n_v2++;
      if (v3) n_v3++;
      check_model(); tick();
    end
  endtask

  typedef struct { bit s; logic re; logic [15:0] ra; logic busy; logic v; logic [7:0] tag; logic dn; } vec_t;
  vec_t tbl[14];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    bit s, a, r;
    clk = 0; rst = 1; start = 0; abort = 0; ready = 1;
    base = 16'h0100; lay_n = 3'd1; lay_e = 5'd2; lay_p = 5'd2; row = 4'd3;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_re", re2, 0);
    chk("rst_ra", ra2, 16'h0100);
    chk("rst_valid", v2, 0);
    chk("rst_tag", tag2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_cfg_err", cerr2, 0);
    rst = 0;

    // Basic iteration, two starts, RD_LAT=2 view.
    tbl = '{
      '{1, 0, 16'h0000, 0, 0, 8'h00, 0},
      '{0, 1, 16'h0100, 1, 0, 8'h00, 0},
      '{0, 1, 16'h0104, 1, 0, 8'h00, 0},
      '{0, 1, 16'h0102, 1, 1, 8'h31, 0},
      '{0, 1, 16'h0106, 1, 1, 8'h31, 0},
      '{0, 0, 16'h0000, 1, 1, 8'h32, 0},
      '{1, 0, 16'h0000, 0, 1, 8'h32, 0},
      '{0, 1, 16'h0101, 1, 0, 8'h00, 0},
      '{0, 1, 16'h0105, 1, 0, 8'h00, 0},
      '{0, 1, 16'h0103, 1, 1, 8'h31, 0},
      '{0, 1, 16'h0107, 1, 1, 8'h31, 0},
      '{0, 0, 16'h0000, 1, 1, 8'h32, 0},
      '{0, 0, 16'h0000, 1, 1, 8'h32, 1},
      '{0, 0, 16'h0000, 0, 0, 8'h00, 0}};
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].s, 0, 1);
      chk($sformatf("tbl%0d_re", i), re2, tbl[i].re);
      if (tbl[i].re) chk($sformatf("tbl%0d_ra", i), ra2, tbl[i].ra);
      chk($sformatf("tbl%0d_busy", i), busy2, tbl[i].busy);
      chk($sformatf("tbl%0d_valid", i), v2, tbl[i].v);
      if (tbl[i].v) chk($sformatf("tbl%0d_tag", i), tag2, tbl[i].tag);
      chk($sformatf("tbl%0d_done", i), done2, tbl[i].dn);
      check_model(); tick();
    end

    // Backpressure: ready 1,0,0,1,0,1,1 then high.
    run_iter(16'hFFE9, 0);
    chk("bp_issues", got_ra.size(), 4);
    if (got_ra.size() == 4) begin
      chk("bp_ra0", got_ra[0], 16'h0100); chk("bp_ra1", got_ra[1], 16'h0104);
      chk("bp_ra2", got_ra[2], 16'h0102); chk("bp_ra3", got_ra[3], 16'h0106);
    end
    chk("bp_valids2", n_v2, 4);
    chk("bp_valids3", n_v3, 4);
    run_iter(16'hFFFF, 0);
    chk("bp_pass_done", n_dn, 1);
    chk("bp_second_first_ra", got_ra[0], 16'h0101);

    // Batch stride.
    set_cfg(16'h0100, 2, 2, 2, 4'd3);
    run_iter(16'hFFFF, 0); chk("batch_s1_ra", got_ra[0], 16'h0100); chk("batch_s1_done", n_dn, 0);
    run_iter(16'hFFFF, 0); chk("batch_s2_ra", got_ra[0], 16'h0101); chk("batch_s2_done", n_dn, 0);
    run_iter(16'hFFFF, 0); chk("batch_s3_ra", got_ra[0], 16'h0108); chk("batch_s3_done", n_dn, 0);
    run_iter(16'hFFFF, 0); chk("batch_s4_ra", got_ra[0], 16'h0109); chk("batch_s4_done", n_dn, 1);

    // Address wrap with start held while busy.
    set_cfg(16'hFFFE, 1, 2, 1, 4'd5);
    run_iter(16'hFFFF, 1);
    chk("wrap_issues", got_ra.size(), 2);
    if (got_ra.size() == 2) begin
      chk("wrap_ra0", got_ra[0], 16'hFFFE); chk("wrap_ra1", got_ra[1], 16'h0000);
    end
    chk("wrap_valids3", n_v3, 2);
    run_iter(16'hFFFF, 0);
    chk("wrap_it2_ra0", got_ra[0], 16'hFFFF);
    chk("wrap_it2_done", n_dn, 1);

    // Abort on the second issue.
    set_cfg(16'h0100, 1, 2, 2, 4'd3);
    apply(1, 0, 1); check_model(); tick();
    apply(0, 0, 1); check_model(); tick();
    apply(0, 1, 1); check_model(); tick();
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 1);
      if (k == 0) chk("abort_re_drop", re2, 0);
      if (v2 || v3) nv++;
      check_model(); tick();
    end
    chk("abort_no_valid", nv, 0);
    run_iter(16'hFFFF, 0);
    chk("abort_restart_ra", got_ra[0], 16'h0100);

    // Config error.
    set_cfg(16'h0100, 1, 2, 0, 4'd3);
    apply(1, 0, 1); check_model(); tick();
    apply(0, 0, 1);
    chk("cfg_err_pulse", cerr2, 1);
    chk("cfg_err_busy", busy2, 0);
    chk("cfg_err_re", re2, 0);
    check_model(); tick();
    apply(0, 0, 1);
    chk("cfg_err_one_cycle", cerr2, 0);
    check_model(); tick();

    // Randomized traffic against the reference.
    set_cfg(16'h0100, 1, 1, 1, 4'd0);
    for (int c = 0; c < 3000; c++) begin
      if (m_q.size() == 0 && m_tail == 0 && m_iter == 0 && m_batch == 0 && $urandom_range(0, 5) == 0) begin
        base  = 16'($urandom);
        lay_n = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
        lay_e = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 3));
        lay_p = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 3));
        row   = 4'($urandom);
      end
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 3) != 0);
      apply(s, a, r);
      check_model(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_load_seq.md
# psum_load_seq

Parametrised psum load sequencer for the Eyeriss PE array. For each `i_load_start` it issues one iteration's worth of GLB psum reads, `p*e` addresses, and tracks iteration and batch progress across starts. It adds a configurable base address, batch stride, GLB ready/backpressure, a configurable read-latency tag/valid pipeline, abort, and config-error detection. It sits between the top-level pass controller and the psum GLB read port, and feeds tags to the array multicast network.

## Interface
- `ADDR_W`, 16, GLB address width
- `DIM_W`, 5, width of `e`/`p` dimensions and their counters
- `N_W`, 3, batch dimension width
- `ROW_W`, 4, row-tag width
- `COL_W`, 4, column-tag width
- `RD_LAT`, 2, GLB read latency in cycles (≥1)

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_load_start`  in  1  start one iteration; accepted only in IDLE
- `i_abort`  in  1  cancel pass; highest priority
- `i_base_addr`  in  ADDR_W  pass base address
- `i_layer_n`  in  N_W  batch count
- `i_layer_e`  in  DIM_W  ofmap width/iteration count
- `i_layer_p`  in  DIM_W  filters per PE set
- `i_row_tag`  in  ROW_W  row tag for this pass
- `i_glb_ready`  in  1  GLB accepts read this cycle
- `o_psum_glb_re`  out  1  read request
- `o_psum_glb_ra`  out  ADDR_W  read address
- `o_psum_valid`  out  1  GLB data valid; tag applies
- `o_psum_tag`  out  ROW_W+COL_W  `{row, col}` aligned with data
- `o_busy`  out  1  state ≠ IDLE
- `o_load_done`  out  1  one-cycle pulse at end of full pass
- `o_cfg_err`  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, LOAD, UPDATE, DONE.
- IDLE→LOAD on `i_load_start` with n, e, p all nonzero.
- Start with any of n, e, p equal to 0: stay in IDLE and pulse `o_cfg_err`.
- Issue: `o_psum_glb_re && i_glb_ready` at a rising edge. `o_psum_glb_re` = (state==LOAD).
- Counters advance only on issue:
  - `cnt_p` is the inner counter (0..p-1).
  - `cnt_e` increments when `cnt_p` wraps (0..e-1).
- Address = base + batch·(p·e·e) + cnt_p·(e·e) + cnt_e·e + iter.
  - Computed at full precision, truncated mod 2^ADDR_W.
  - Wrap is legal and unflagged.
- LOAD→UPDATE on the issue with cnt_p=p-1 and cnt_e=e-1; cnt_p and cnt_e return to 0.
- UPDATE (1 cycle):
  - iter ← iter+1, or 0 if iter=e-1.
  - On iter wrap, batch ← batch+1, or 0 if batch=n-1.
  - If both wrap → DONE, otherwise → IDLE.
- DONE (1 cycle): `o_load_done`=1, then → IDLE. iter and batch are already 0, so the next pass starts clean.
- Column tag = cnt_e+1, truncated to COL_W. Row tag = `i_row_tag`, sampled at start.
- Tag/valid pipeline:
  - RD_LAT-deep shift register of {issue, tag}.
  - `o_psum_valid`/`o_psum_tag` appear exactly RD_LAT cycles after the issue edge.
  - The pipeline keeps draining after LOAD exits.
- Config inputs must be stable while `o_busy` or iter/batch are nonzero; if they change, behaviour is undefined.
- `i_load_start` outside IDLE is ignored, with no error.
- `i_abort` (any state):
  - Next state IDLE.
  - cnt_p, cnt_e, iter, batch cleared.
  - Tag pipeline valids cleared.
  - No `o_load_done`.
  - Overrides a same-cycle start.

## Timing
- Reset: state IDLE, all counters 0, pipeline valids 0.
- Reset values: `o_psum_glb_re`=0, `o_psum_glb_ra`=`i_base_addr` (combinational from zero counters), `o_psum_valid`=0, `o_psum_tag`=0, `o_busy`=0, `o_load_done`=0, `o_cfg_err`=0.
- Start accepted at edge T → `o_psum_glb_re`=1 from T+1.
- With ready held high: one issue per cycle, p·e cycles in LOAD, then UPDATE, then IDLE or DONE.
- `o_psum_glb_ra`/`re` are driven from registered state; they hold stable while `i_glb_ready`=0.
- Reset mid-pass behaves identically to abort plus output reset.

## Test plan
- Basic iteration: base=0x100, n=1, e=2, p=2, row=3, ready=1. Start #1 → ra 0x100, 0x104, 0x102, 0x106; tags 0x31, 0x31, 0x32, 0x32; valid 2 cycles after each issue. Start #2 → 0x101, 0x105, 0x103, 0x107, then `o_load_done` for one cycle.
- Backpressure: same config, ready pattern 1,0,0,1,0,1,1 → ra held during ready=0; exactly 4 valids; no duplicate or skipped addresses.
- Batch stride: n=2, e=2, p=2 → starts 3 and 4 use offset 8 (0x108…); done only after start 4.
- Abort: abort on the 2nd issue of start #1 → re drops next cycle; pending valids suppressed. A new start restarts at 0x100.
- Config error: start with p=0 → `o_cfg_err` pulse, `o_busy` stays 0, no re.
- Latency/wrap: RD_LAT=3, base=0xFFFE, e=2, p=1 → ra 0xFFFE, 0x0000; valid 3 cycles after each issue; start while busy ignored.
